// File: rtl/wave_pwm_gen.sv
// wave_pwm_gen: tick-driven 8-bit waveform generator with PWM rendering of the sample
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset, clears all state
//   tick        phase-advance pulse from the frequency divider
//   init        synchronous restart, overrides tick
//   wave_sel    requested waveform: 00 saw, 01 triangle, 10 square, 11 reverse saw
//   sample      registered 8-bit waveform sample
//   pwm_out     registered PWM rendering of the sample (256-clk frames)
//   period_done one-cycle pulse when the phase wraps 255->0
module wave_pwm_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       init,
    input  logic [1:0] wave_sel,
    output logic [7:0] sample,
    output logic       pwm_out,
    output logic       period_done
);
    logic [7:0] phase;
    logic [1:0] sel_act;
    logic [7:0] pwm_cnt;
    logic [7:0] duty;
    logic [7:0] phase_inc;
    logic       wrap;
    logic [7:0] f_start;
    logic [7:0] f_next;

    function automatic logic [7:0] wave_f(input logic [7:0] p, input logic [1:0] s);
        logic [7:0] tri_v;
        tri_v = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
        return s == 2'b00 ? p :
               s == 2'b01 ? tri_v :
               s == 2'b10 ? {8{~p[7]}} : ~p;
    endfunction

    always_comb begin
        phase_inc = phase + 8'd1;
        wrap      = phase == 8'hff;
        f_start   = wave_f(8'd0, wave_sel);
        f_next    = wave_f(phase_inc, sel_act);
    end

    // A new waveform selection is only latched at a wrap or init, so a
    // mid-period change never introduces a discontinuity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= 8'd0;
            sel_act     <= 2'b00;
            sample      <= 8'd0;
            period_done <= 1'b0;
        end else if (init) begin
            phase       <= 8'd0;
            sel_act     <= wave_sel;
            sample      <= f_start;
            period_done <= 1'b0;
        end else if (tick) begin
            phase       <= phase_inc;
            sel_act     <= wrap ? wave_sel : sel_act;
            sample      <= wrap ? f_start : f_next;
            period_done <= wrap;
        end else begin
            period_done <= 1'b0;
        end
    end

    // Duty is reloaded only at the frame boundary so each PWM frame renders
    // one stable sample value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            duty    <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= init ? 8'd0 : pwm_cnt + 8'd1;
            duty    <= init ? f_start : (pwm_cnt == 8'hff ? sample : duty);
            pwm_out <= pwm_cnt < duty;
        end
    end
endmodule

// File: tb/tb_wave_pwm_gen.sv
// tb_wave_pwm_gen: directed self-checking bench for wave_pwm_gen
module tb_wave_pwm_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       init = 1'b0;
    logic [1:0] wave_sel = 2'b00;
    logic [7:0] sample;
    logic       pwm_out;
    logic       period_done;

    int checks = 0;
    int failures = 0;
    int pd_cnt = 0;
    logic [7:0] pd_sample = 8'd0;
    int hi;

    wave_pwm_gen dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .init(init),
        .wave_sel(wave_sel),
        .sample(sample),
        .pwm_out(pwm_out),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_done) begin
            pd_cnt    <= pd_cnt + 1;
            pd_sample <= sample;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_init(input logic [1:0] s);
        @(negedge clk);
        wave_sel = s;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic do_tick(input int gap);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(0);
    endtask

    task automatic count_pwm(output int h);
        h = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) h++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_sample", sample, 0);
        check("reset_pwm", pwm_out, 0);
        check("reset_pd", period_done, 0);
        rst = 1'b0;

        // async reset mid-period
        do_init(2'b00);
        ticks(77);
        check("pre_rst_sample", sample, 77);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sample", sample, 0);
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_pd", period_done, 0);
        @(negedge clk);
        rst = 1'b0;
        do_tick(0);
        check("post_rst_tick", sample, 1);

        // sawtooth with wrap
        do_init(2'b00);
        check("saw_init", sample, 0);
        pd_cnt = 0;
        for (int i = 1; i <= 256; i++) begin
            do_tick(0);
            check("saw_sample", sample, i % 256);
            if (i == 256) check("saw_wrap_pd", period_done, 1);
            else if (period_done) check("saw_early_pd", period_done, 0);
            repeat (3) @(negedge clk);
        end
        check("saw_pd_count", pd_cnt, 1);
        check("saw_pd_sample", pd_sample, 0);

        // triangle then square
        do_init(2'b01);
        ticks(127);
        check("tri_127", sample, 254);
        do_tick(0);
        check("tri_128", sample, 254);
        do_tick(0);
        check("tri_129", sample, 252);
        ticks(126);
        check("tri_255", sample, 0);
        wave_sel = 2'b10;
        do_tick(0);
        check("sq_wrap", sample, 255);
        check("sq_wrap_pd", period_done, 1);
        @(negedge clk);
        check("sq_pd_clear", period_done, 0);
        for (int i = 1; i < 256; i++) begin
            do_tick(0);
            check("sq_sample", sample, i < 128 ? 255 : 0);
        end

        // deferred select
        do_init(2'b00);
        ticks(150);
        check("def_150", sample, 150);
        wave_sel = 2'b11;
        do_tick(0);
        check("def_151", sample, 151);
        ticks(104);
        check("def_255", sample, 255);
        do_tick(0);
        check("def_wrap", sample, 255);
        do_tick(0);
        check("def_after", sample, 254);

        // init priority over tick
        do_init(2'b00);
        ticks(40);
        check("pri_40", sample, 40);
        pd_cnt = 0;
        @(negedge clk);
        wave_sel = 2'b11;
        init = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        init = 1'b0;
        tick = 1'b0;
        check("pri_sample", sample, 255);
        check("pri_pd", period_done, 0);
        do_tick(0);
        check("pri_next", sample, 254);
        check("pri_pd_count", pd_cnt, 0);

        // PWM rendering
        do_init(2'b00);
        ticks(64);
        check("pwm64_sample", sample, 64);
        repeat (512) @(negedge clk);
        count_pwm(hi);
        check("pwm64_frame1", hi, 64);
        count_pwm(hi);
        check("pwm64_frame2", hi, 64);

        do_init(2'b00);
        repeat (512) @(negedge clk);
        count_pwm(hi);
        check("pwm0_frame", hi, 0);

        ticks(255);
        check("pwm255_sample", sample, 255);
        repeat (512) @(negedge clk);
        count_pwm(hi);
        check("pwm255_frame", hi, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
